// File: rtl/set_input_ctrl_pkg.sv
// Shared definitions for the push-button front end that drives the setting units.
// Holds the controller state encoding, default timing constants and the select-width helper.
package set_input_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } ctrl_state_t;

    localparam int DEF_NUM_TARGETS  = 3;
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;
    localparam int DEF_TIMEOUT      = 10000;
    localparam int DEF_CNT_W        = 14;

    // Bit positions of the buttons inside the packed button vectors.
    localparam int BTN_MODE = 0;
    localparam int BTN_SET  = 1;
    localparam int BTN_UP   = 2;
    localparam int BTN_DOWN = 3;
    localparam int NUM_BTNS = 4;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/set_input_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for one raw button plus a registered rising-edge detector.
// The event pulse appears three clocks after the raw rising edge; level is the synchronised button.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic rise_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            rise_reg  <= sync2_reg & ~prev_reg;
        end
    end

    assign level = sync2_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/set_input_ctrl.sv
// Shares set/up/down buttons between several setting units: mode selects the unit, set opens an
// edit session, up/down auto-repeat while held, and the session ends on unit done or inactivity.
module set_input_ctrl
    import set_input_ctrl_pkg::*;
#(
    parameter int NUM_TARGETS  = DEF_NUM_TARGETS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                tick,
    input  logic                                mode_btn,
    input  logic                                set_btn,
    input  logic                                up_btn,
    input  logic                                down_btn,
    input  logic [NUM_TARGETS-1:0]              tgt_done,
    output logic [NUM_TARGETS-1:0]              tgt_set,
    output logic [NUM_TARGETS-1:0]              tgt_up,
    output logic [NUM_TARGETS-1:0]              tgt_down,
    output logic [sel_width(NUM_TARGETS)-1:0]   sel,
    output logic                                editing,
    output logic                                commit,
    output logic [NUM_TARGETS-1:0]              abort
);

    localparam int SEL_W = sel_width(NUM_TARGETS);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_TARGETS - 1);
    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LD   = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_rise;

    assign btn_raw = {down_btn, up_btn, set_btn, mode_btn};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_sync_edge u_sync (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .level (btn_level[gi]),
                .rise  (btn_rise[gi])
            );
        end
    endgenerate

    // Mode and set are only used as events; their levels are deliberately dropped.
    logic unused_levels;
    assign unused_levels = btn_level[BTN_MODE] ^ btn_level[BTN_SET];

    ctrl_state_t      state_reg;
    logic [CNT_W-1:0] timeout_cnt_reg;
    logic [CNT_W-1:0] rep_cnt_reg;
    logic             rep_active_reg;
    logic             rep_is_down_reg;

    logic                   ev_mode, ev_set, ev_up, ev_down, any_evt;
    logic [NUM_TARGETS-1:0] sel_onehot;
    logic                   done_hit;
    logic                   rep_level;
    logic                   rep_due;

    always_comb begin
        ev_mode    = btn_rise[BTN_MODE];
        ev_set     = btn_rise[BTN_SET];
        ev_up      = btn_rise[BTN_UP];
        ev_down    = btn_rise[BTN_DOWN];
        any_evt    = |btn_rise;
        sel_onehot = NUM_TARGETS'(1) << sel;
        done_hit   = |(tgt_done & sel_onehot);
        rep_level  = rep_is_down_reg ? btn_level[BTN_DOWN] : btn_level[BTN_UP];
        rep_due    = rep_active_reg && rep_level && tick && (rep_cnt_reg <= CNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            sel             <= '0;
            editing         <= 1'b0;
            tgt_set         <= '0;
            tgt_up          <= '0;
            tgt_down        <= '0;
            commit          <= 1'b0;
            abort           <= '0;
            timeout_cnt_reg <= '0;
            rep_cnt_reg     <= '0;
            rep_active_reg  <= 1'b0;
            rep_is_down_reg <= 1'b0;
        end else begin
            tgt_set  <= '0;
            tgt_up   <= '0;
            tgt_down <= '0;
            commit   <= 1'b0;
            abort    <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (ev_set) begin
                        tgt_set         <= sel_onehot;
                        state_reg       <= ST_EDIT;
                        editing         <= 1'b1;
                        timeout_cnt_reg <= '0;
                        rep_active_reg  <= 1'b0;
                    end else if (ev_mode) begin
                        sel <= (sel == SEL_MAX) ? '0 : sel + SEL_W'(1);
                    end
                end
                ST_EDIT: begin
                    if (done_hit) begin
                        commit         <= 1'b1;
                        state_reg      <= ST_IDLE;
                        editing        <= 1'b0;
                        rep_active_reg <= 1'b0;
                    end else if (timeout_cnt_reg >= TIMEOUT_C) begin
                        abort          <= sel_onehot;
                        state_reg      <= ST_IDLE;
                        editing        <= 1'b0;
                        rep_active_reg <= 1'b0;
                    end else begin
                        if (ev_set) begin
                            tgt_set <= sel_onehot;
                        end else if (ev_up && ev_down) begin
                            rep_active_reg <= 1'b0;
                        end else if (ev_up) begin
                            tgt_up          <= sel_onehot;
                            rep_active_reg  <= 1'b1;
                            rep_is_down_reg <= 1'b0;
                            rep_cnt_reg     <= DELAY_LD;
                        end else if (ev_down) begin
                            tgt_down        <= sel_onehot;
                            rep_active_reg  <= 1'b1;
                            rep_is_down_reg <= 1'b1;
                            rep_cnt_reg     <= DELAY_LD;
                        end else if (rep_active_reg) begin
                            if (!rep_level) begin
                                rep_active_reg <= 1'b0;
                            end else if (tick) begin
                                if (rep_due) begin
                                    if (rep_is_down_reg) tgt_down <= sel_onehot;
                                    else                 tgt_up   <= sel_onehot;
                                    rep_cnt_reg <= RATE_LD;
                                end else begin
                                    rep_cnt_reg <= rep_cnt_reg - CNT_W'(1);
                                end
                            end
                        end
                        // Repeat pulses count as activity so a held button never times out.
                        if (any_evt || rep_due) begin
                            timeout_cnt_reg <= '0;
                        end else if (tick && (timeout_cnt_reg < TIMEOUT_C)) begin
                            timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    editing   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_input_ctrl.sv
// Bench for set_input_ctrl: directed button scenarios, a per-cycle behavioural model comparison,
// and literal expectations on pulse counts and values.
module tb_set_input_ctrl;

    localparam int N     = 3;
    localparam int DELAY = 500;
    localparam int RATE  = 100;
    localparam int TOUT  = 10000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic [3:0]   btns = 4'b0;     // {down, up, set, mode}
    logic [N-1:0] tgt_done = '0;
    logic [N-1:0] tgt_set, tgt_up, tgt_down, abort;
    logic [1:0]   sel;
    logic         editing, commit;

    set_input_ctrl #(
        .NUM_TARGETS(N), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE),
        .TIMEOUT(TOUT), .CNT_W(14)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .mode_btn(btns[0]), .set_btn(btns[1]), .up_btn(btns[2]), .down_btn(btns[3]),
        .tgt_done(tgt_done), .tgt_set(tgt_set), .tgt_up(tgt_up), .tgt_down(tgt_down),
        .sel(sel), .editing(editing), .commit(commit), .abort(abort)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        tick = ~tick;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: raw button history, event = rising edge seen 3 clocks late,
    // repeat pulses derived from ticks held since the press.
    logic [3:0]   hist [4];
    logic [3:0]   m_ev, m_lvl;
    logic [N-1:0] m_oh;
    logic [N-1:0] exp_set = '0, exp_up = '0, exp_dn = '0, exp_abort = '0;
    logic         exp_commit = 1'b0;
    int m_edit = 0, m_sel = 0, m_idle = 0, m_rep = 0, m_held = 0, m_act = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) hist[k] = 4'b0;
            m_edit = 0; m_sel = 0; m_idle = 0; m_rep = 0; m_held = 0;
            exp_set = '0; exp_up = '0; exp_dn = '0; exp_abort = '0; exp_commit = 1'b0;
        end else begin
            exp_set = '0; exp_up = '0; exp_dn = '0; exp_abort = '0; exp_commit = 1'b0;
            m_oh  = N'(1 << m_sel);
            m_ev  = hist[2] & ~hist[3];
            m_lvl = hist[1];
            if (m_edit == 0) begin
                if (m_ev[1]) begin
                    exp_set = m_oh; m_edit = 1; m_idle = 0; m_rep = 0;
                end else if (m_ev[0]) begin
                    m_sel = (m_sel + 1) % N;
                end
            end else if ((tgt_done & m_oh) != 0) begin
                exp_commit = 1'b1; m_edit = 0; m_rep = 0;
            end else if (m_idle == TOUT) begin
                exp_abort = m_oh; m_edit = 0; m_rep = 0;
            end else begin
                m_act = (m_ev != 0) ? 1 : 0;
                if (m_ev[1]) exp_set = m_oh;
                else if (m_ev[2] && m_ev[3]) m_rep = 0;
                else if (m_ev[2]) begin exp_up = m_oh; m_rep = 1; m_held = 0; end
                else if (m_ev[3]) begin exp_dn = m_oh; m_rep = 2; m_held = 0; end
                else if (m_rep != 0) begin
                    if (!m_lvl[m_rep + 1]) m_rep = 0;
                    else if (tick) begin
                        m_held++;
                        if (m_held >= DELAY && (m_held - DELAY) % RATE == 0) begin
                            if (m_rep == 1) exp_up = m_oh; else exp_dn = m_oh;
                            m_act = 1;
                        end
                    end
                end
                if (m_act != 0) m_idle = 0;
                else if (tick && m_idle < TOUT) m_idle++;
            end
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btns;
        end
    end

    // Per-cycle compare against the model, plus pulse tallies for the literal checks.
    int cnt_set = 0, cnt_up = 0, cnt_dn = 0, cnt_commit = 0, cnt_abort = 0;
    logic [N-1:0] last_set = '0, last_up = '0, last_abort = '0;

    always @(negedge clk) begin
        chk("cycle_model",
            {17'b0, tgt_set, tgt_up, tgt_down, abort, sel, editing, commit},
            {17'b0, exp_set, exp_up, exp_dn, exp_abort, 2'(m_sel), (m_edit != 0), exp_commit});
        if (tgt_set  != 0) begin cnt_set++; last_set = tgt_set; end
        if (tgt_up   != 0) begin cnt_up++;  last_up  = tgt_up;  end
        if (tgt_down != 0) cnt_dn++;
        if (commit)        cnt_commit++;
        if (abort    != 0) begin cnt_abort++; last_abort = abort; end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        @(negedge clk);
        btns = btns | mask;
        cycles(hold);
        btns = btns & ~mask;
        cycles(gap);
    endtask

    task automatic pulse_done(input logic [N-1:0] v);
        @(negedge clk);
        tgt_done = v;
        @(negedge clk);
        tgt_done = '0;
        cycles(4);
    endtask

    int b_set, b_up, b_dn, b_commit, b_abort;
    int seen;
    logic [1:0] sel_exp [4];

    task automatic snap();
        b_set = cnt_set; b_up = cnt_up; b_dn = cnt_dn; b_commit = cnt_commit; b_abort = cnt_abort;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel_exp[0] = 2'd1; sel_exp[1] = 2'd2; sel_exp[2] = 2'd0; sel_exp[3] = 2'd1;
        cycles(5);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_editing", 32'(editing), 32'd0);
        reset = 1'b1;
        cycles(3);

        // 1: mode cycles the selection, nothing forwarded
        snap();
        for (int i = 0; i < 4; i++) begin
            press(4'b0001, 2, 6);
            chk($sformatf("mode_sel_%0d", i), 32'(sel), 32'(sel_exp[i]));
        end
        chk("mode_no_pulses", 32'(cnt_set + cnt_up + cnt_dn + cnt_abort - b_set - b_up - b_dn - b_abort), 32'd0);
        chk("mode_editing", 32'(editing), 32'd0);

        // 2: set, up, then done from unit 1
        snap();
        press(4'b0010, 2, 6);
        chk("set_count", 32'(cnt_set - b_set), 32'd1);
        chk("set_value", 32'(last_set), 32'b010);
        chk("set_editing", 32'(editing), 32'd1);
        press(4'b0100, 2, 6);
        chk("up_count", 32'(cnt_up - b_up), 32'd1);
        chk("up_value", 32'(last_up), 32'b010);
        pulse_done(3'b010);
        chk("done_commit", 32'(cnt_commit - b_commit), 32'd1);
        chk("done_editing", 32'(editing), 32'd0);

        // 3: auto-repeat while up held for roughly 825 ticks
        press(4'b0010, 2, 6);
        snap();
        press(4'b0100, 1650, 10);
        chk("repeat_count", 32'(cnt_up - b_up), 32'd5);
        chk("repeat_no_down", 32'(cnt_dn - b_dn), 32'd0);
        cycles(300);
        chk("repeat_after_release", 32'(cnt_up - b_up), 32'd5);

        // 4: inactivity abort, then a late done is ignored
        seen = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (cnt_abort != b_abort) begin seen = 1; break; end
        end
        chk("abort_seen", 32'(seen), 32'd1);
        chk("abort_value", 32'(last_abort), 32'b010);
        cycles(3);
        chk("abort_editing", 32'(editing), 32'd0);
        chk("abort_once", 32'(cnt_abort - b_abort), 32'd1);
        pulse_done(3'b010);
        chk("abort_no_commit", 32'(cnt_commit - b_commit), 32'd0);

        // 5: priorities and foreign done
        press(4'b0001, 2, 6);
        press(4'b0001, 2, 6);
        chk("sel_back_to_0", 32'(sel), 32'd0);
        press(4'b0010, 2, 6);
        snap();
        press(4'b0110, 2, 6);
        chk("setup_set_only", 32'(cnt_set - b_set), 32'd1);
        chk("setup_no_up", 32'(cnt_up - b_up), 32'd0);
        press(4'b1100, 2, 6);
        chk("updown_nothing", 32'(cnt_up + cnt_dn - b_up - b_dn), 32'd0);
        pulse_done(3'b100);
        chk("foreign_done_ignored", 32'(cnt_commit - b_commit), 32'd0);
        chk("foreign_done_editing", 32'(editing), 32'd1);
        pulse_done(3'b001);
        chk("own_done_commit", 32'(cnt_commit - b_commit), 32'd1);

        // 6: reset during auto-repeat
        press(4'b0010, 2, 6);
        snap();
        @(negedge clk);
        btns = 4'b0100;
        cycles(1300);
        chk("pre_reset_repeats", 32'((cnt_up - b_up) >= 2), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {12'b0, tgt_set, tgt_up, tgt_down, abort, sel, editing, commit}, 32'd0);
        btns = 4'b0;
        cycles(4);
        reset = 1'b1;
        snap();
        cycles(12);
        chk("post_reset_sel", 32'(sel), 32'd0);
        chk("post_reset_editing", 32'(editing), 32'd0);
        chk("post_reset_quiet", 32'(cnt_set + cnt_up + cnt_dn + cnt_commit + cnt_abort
                                     - b_set - b_up - b_dn - b_commit - b_abort), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/set_input_ctrl.md
Name: set_input_ctrl

Overview:
- Front-end controller that shares the set/up/down push-buttons between several 12-hour setting units (time-set, alarm-set, ...).
- Synchronises and edge-detects the raw buttons, and uses a mode button to pick the target unit.
- Routes single-cycle set/up/down pulses to the selected unit only, adds auto-repeat for held up/down, and watches for the unit's propagate (done) strobe.
- Aborts an edit session after an inactivity timeout. Sits between the button pins and the setting units.

Parameters:
NUM_TARGETS, 3, number of setting units served (2..8)
REPEAT_DELAY, 500, ticks up/down must be held before auto-repeat starts
REPEAT_RATE, 100, ticks between auto-repeat pulses
TIMEOUT, 10000, ticks with no button activity in EDIT before abort
CNT_W, 14, width of tick counters (must hold TIMEOUT)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle timebase enable (nominally 1 kHz)
mode_btn  in  1  raw mode button, active-high, asynchronous to clk
set_btn  in  1  raw set button
up_btn  in  1  raw up button
down_btn  in  1  raw down button
tgt_done  in  NUM_TARGETS  per-unit propagate strobes
tgt_set  out  NUM_TARGETS  one-hot set pulse to selected unit
tgt_up  out  NUM_TARGETS  one-hot up pulse
tgt_down  out  NUM_TARGETS  one-hot down pulse
sel  out  clog2(NUM_TARGETS)  currently selected unit
editing  out  1  high while in EDIT
commit  out  1  one-cycle pulse when selected unit signals done
abort  out  NUM_TARGETS  one-hot one-cycle abort to selected unit on timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - sel=0, state IDLE, all pulse outputs 0, editing=0.
  - All counters and synchroniser flops 0.
- Input conditioning:
  - Each button passes a 2-flop synchroniser, then a rising-edge detector.
  - A press yields exactly one event, 3 clk after the raw rising edge.
  - No debounce; buttons are debounced upstream.
- Pulse outputs are registered, one clk wide, only bit [sel] can be set, and at most one of tgt_set/tgt_up/tgt_down is set per cycle.
- IDLE state:
  - mode event: sel <= sel+1, wrapping NUM_TARGETS-1 -> 0.
  - set event: pulse tgt_set[sel], go EDIT, clear the timeout counter. sel is frozen for the session.
  - up/down events are ignored.
- EDIT state:
  - editing=1; mode events are ignored.
  - set event: forward as tgt_set[sel].
  - up or down event: forward the matching pulse. Load the repeat counter with REPEAT_DELAY.
  - While that button stays held (synchronised level), decrement on tick. At 0, emit another pulse and reload with REPEAT_RATE.
  - Release clears auto-repeat.
  - Priority in the same cycle: set > up > down. An up and down event in the same cycle forwards nothing and stops auto-repeat.
  - Any button event clears the timeout counter; otherwise it increments on tick.
  - Timeout counter reaching TIMEOUT: pulse abort[sel], go IDLE.
  - tgt_done[sel]=1: pulse commit next cycle, go IDLE. Done takes priority over a timeout in the same cycle.
  - tgt_done bits of non-selected units are ignored.
- Counters saturate and never wrap. Forwarded pulses appear 1 clk after the internal event.
- Reset asserted mid-session drops to IDLE immediately with no commit or abort.

Decomposition:
- Shared package holds:
  - state encoding IDLE/EDIT;
  - default REPEAT_DELAY, REPEAT_RATE, TIMEOUT;
  - SEL_W derived from NUM_TARGETS.
- One natural sub-module: btn_sync_edge (2-flop sync + rising-edge + level output), instantiated four times.

Test Plan:
1. Reset, then mode pressed 4 times with NUM_TARGETS=3 -> sel sequence 1,2,0,1; no tgt_* pulses; editing=0.
2. sel=1, press set -> tgt_set=3'b010 once, editing=1. Then up -> tgt_up=3'b010 once. Then tgt_done[1]=1 -> commit one cycle later, editing=0.
3. EDIT, hold up for 800 ticks (REPEAT_DELAY=500, RATE=100) -> 1 initial pulse + repeats at ticks 500,600,700,800 = 5 tgt_up pulses. Release -> no more.
4. EDIT, no buttons for 10000 ticks -> abort[sel] pulses once, editing=0. A later tgt_done produces no commit.
5. EDIT, set and up rising in the same cycle -> only tgt_set. Up and down together -> no pulse. tgt_done[2] while sel=0 -> ignored.
6. Assert reset during auto-repeat -> all outputs 0 asynchronously. After release: sel=0, IDLE, no pulses.
